// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-cell modulo counter: JK input codes and a
// ceiling-log2 helper used for elaboration-time parameter checks.
package jk_mod_counter_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  localparam int MAX_WIDTH = 16;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_ff_cell.sv
// One-bit JK flip-flop, falling-edge clocked, synchronous active-low reset
// to INIT.
module jk_ff_cell
  import jk_mod_counter_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_reg;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      q_reg <= INIT;
    end else begin
      case ({j, k})
        JK_HOLD: q_reg <= q_reg;
        JK_RST:  q_reg <= 1'b0;
        JK_SET:  q_reg <= 1'b1;
        default: q_reg <= ~q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter with parallel load; each state bit lives in
// a JK cell driven from a combinational next-state mux.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("jk_mod_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("jk_mod_counter: RESET_VALUE must be below MODULUS");
    end
  endgenerate

  // 17-bit copies so MODULUS == 2**16 still compares correctly.
  localparam logic [16:0]      MOD_EXT = 17'(MODULUS);
  localparam logic [16:0]      MAX_EXT = 17'(MODULUS - 1);
  localparam logic [16:0]      RST_EXT = 17'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_VEC = RST_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_next;
  logic [WIDTH-1:0] next_val;
  logic [16:0]      d_ext;
  logic             at_max;
  logic             at_zero;
  logic             d_out_of_range;
  logic             tc_int;
  logic             wrap_reg;
  logic             load_err_reg;

  assign d_ext = 17'(d);

  always_comb begin
    at_max         = (q_reg == MAX_VAL);
    at_zero        = (q_reg == '0);
    d_out_of_range = (d_ext >= MOD_EXT);
    if (up_dn) begin
      count_next = at_max ? '0 : q_reg + WIDTH'(1);
    end else begin
      count_next = at_zero ? MAX_VAL : q_reg - WIDTH'(1);
    end
    load_next = d_out_of_range ? MAX_VAL : d;
    next_val  = load ? load_next : count_next;
    tc_int    = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic [1:0] jk_code;

      always_comb begin
        jk_code = JK_HOLD;
        if (load) begin
          jk_code = next_val[gi] ? JK_SET : JK_RST;
        end else if (en && (q_reg[gi] ^ next_val[gi])) begin
          jk_code = JK_TOG;
        end
      end

      jk_ff_cell #(
        .INIT (RST_VEC[gi])
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (jk_code[1]),
        .k     (jk_code[0]),
        .q     (q_reg[gi])
      );
    end
  endgenerate

  // A wrap happens exactly on an edge where tc was high.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      wrap_reg <= tc_int;
      if (load && d_out_of_range) begin
        load_err_reg <= 1'b1;
      end
    end
  end

  assign q        = q_reg;
  assign q_n      = ~q_reg;
  assign tc       = tc_int;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;

endmodule
